io_port_fifo: RTL and testbench

IO_PORT_FIFO -- requirements
Module: io_port_fifo

---
 rtl/io_port_fifo.sv | 105 ++++++++++
 tb/tb_io_port_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/io_port_fifo.sv
// io_port_fifo: show-ahead word FIFO between a producer and the CPU I/O port.
// Optional sticky error flags are enabled by defining IO_PORT_FIFO_ERROR_FLAGS_EN.
module io_port_fifo #(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  io_rden,
    output logic [WORD_WIDTH-1:0] io_read_data,
    output logic                  io_read_EF,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  underflow_err,
    output logic                  overflow_err
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic [ADDR_WIDTH:0]   occ;
    logic                  push;
    logic                  pop;

    // Handshake flags come only from the registered occupancy.
    always_comb begin
        in_ready   = (occ != FULL_COUNT);
        io_read_EF = (occ != '0);
        push       = in_valid && in_ready;
        pop        = io_rden && io_read_EF;
        count      = occ;
    end

    // Show-ahead: head entry is presented without a read cycle.
    always_comb begin
        io_read_data = mem[head];
    end

    // Storage is never reset; stale words are masked by the occupancy.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                tail <= tail + ADDR_WIDTH'(1);
            end
            if (pop) begin
                head <= head + ADDR_WIDTH'(1);
            end
        end
    end

    // Occupancy distinguishes full from empty when head equals tail.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   occ <= occ + (ADDR_WIDTH + 1)'(1);
                2'b01:   occ <= occ - (ADDR_WIDTH + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef IO_PORT_FIFO_ERROR_FLAGS_EN
    logic uf_q;
    logic of_q;

    // Sticky misuse flags, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            if (io_rden && !io_read_EF) begin
                uf_q <= 1'b1;
            end
            if (in_valid && !in_ready) begin
                of_q <= 1'b1;
            end
        end
    end

    assign underflow_err = uf_q;
    assign overflow_err  = of_q;
`else
    assign underflow_err = 1'b0;
    assign overflow_err  = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_fifo.sv
// tb_io_port_fifo: scoreboard bench for io_port_fifo.
// Define IO_PORT_FIFO_ERROR_FLAGS_EN for both DUT and bench to check the flags.
module tb_io_port_fifo;

    localparam int W = 36;
    localparam int D = 8;
    localparam int A = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         io_rden = 1'b0;
    logic [W-1:0] io_read_data;
    logic         io_read_EF;
    logic [A:0]   count;
    logic         underflow_err;
    logic         overflow_err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           occ = 0;
    bit           uf_m = 1'b0;
    bit           of_m = 1'b0;

    io_port_fifo #(
        .WORD_WIDTH(W),
        .DEPTH(D),
        .ADDR_WIDTH(A)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .io_rden(io_rden),
        .io_read_data(io_read_data),
        .io_read_EF(io_read_EF),
        .count(count),
        .underflow_err(underflow_err),
        .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT against the model before each rising edge.
    initial begin
        logic [W-1:0] want;
        bit           p;
        bit           q;
        forever begin
            @(negedge clock);
            check("count", 64'(count), 64'(occ));
            check("read_EF", 64'(io_read_EF), 64'(occ > 0));
            check("in_ready", 64'(in_ready), 64'(occ < D));
            check("underflow_err", 64'(underflow_err), 64'(uf_m));
            check("overflow_err", 64'(overflow_err), 64'(of_m));
            if (occ > 0) begin
                check("head_data", 64'(io_read_data), 64'(exp_q[0]));
            end
            if (!reset) begin
                p = in_valid && (occ < D);
                q = io_rden && (occ > 0);
`ifdef IO_PORT_FIFO_ERROR_FLAGS_EN
                if (io_rden && occ == 0) uf_m = 1'b1;
                if (in_valid && occ == D) of_m = 1'b1;
`endif
                if (q) begin
                    want = exp_q.pop_front();
                    check("pop_data", 64'(io_read_data), 64'(want));
                end
                occ = occ + int'(p) - int'(q);
            end
        end
    end

    // Driver: one cycle of stimulus, recording accepted words.
    task automatic step(input bit v, input logic [W-1:0] d, input bit r);
        @(posedge clock);
        #1;
        in_valid = v;
        in_data  = d;
        io_rden  = r;
        if (v && occ < D) begin
            exp_q.push_back(d);
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #3;
        reset    = 1'b1;
        in_valid = 1'b0;
        io_rden  = 1'b0;
        occ      = 0;
        uf_m     = 1'b0;
        of_m     = 1'b0;
        exp_q.delete();
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_EF", 64'(io_read_EF), 64'd0);
        check("rst_uf", 64'(underflow_err), 64'd0);
        check("rst_of", 64'(overflow_err), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < D + 2; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [63:0] r;
        int pv;
        int pr;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Three words in order.
        step(1'b1, 36'h000000001, 1'b0);
        step(1'b1, 36'h000000002, 1'b0);
        step(1'b1, 36'h000000003, 1'b0);
        step(1'b0, '0, 1'b0);
        @(negedge clock);
        check("three_count", 64'(count), 64'd3);
        check("three_head", 64'(io_read_data), 64'h1);
        drain();

        // Fill, drop a ninth word, drain.
        for (int i = 0; i < D; i++) step(1'b1, W'(36'h100 + i), 1'b0);
        step(1'b1, 36'hFFFFFFFFF, 1'b0);
        step(1'b0, '0, 1'b0);
        @(negedge clock);
        check("full_count", 64'(count), 64'd8);
        check("full_ready", 64'(in_ready), 64'd0);
        drain();

        // Steady push and pop across pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, W'(36'h200 + i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 36'h0000000AA, 1'b1);
        step(1'b0, '0, 1'b0);
        @(negedge clock);
        check("steady_count", 64'(count), 64'd4);
        drain();

        // Pop while empty.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Empty then single push becomes visible after its edge.
        do_reset();
        @(negedge clock);
        check("pre_push_EF", 64'(io_read_EF), 64'd0);
        step(1'b1, 36'h123456789, 1'b0);
        step(1'b0, '0, 1'b0);
        @(negedge clock);
        check("post_push_EF", 64'(io_read_EF), 64'd1);
        check("post_push_data", 64'(io_read_data), 64'h123456789);

        // Push while full, then reset between edges.
        for (int i = 0; i < D; i++) step(1'b1, W'(36'h300 + i), 1'b0);
        step(1'b1, 36'hFFFFFFFFF, 1'b0);
        step(1'b0, '0, 1'b0);
        do_reset();

        // Randomized traffic with shifting bias.
        for (int i = 0; i < 3000; i++) begin
            pv = (i < 1000) ? 70 : (i < 2000) ? 35 : 55;
            pr = (i < 1000) ? 40 : (i < 2000) ? 70 : 50;
            r = {$urandom(), $urandom()};
            step($urandom_range(99) < pv, r[W-1:0], $urandom_range(99) < pr);
            if (i == 1500) do_reset();
        end
        drain();
        @(negedge clock);
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
